tl_ul_a_arbiter: RTL and testbench
==================================

# tl_ul_a_arbiter

Two-to-one TileLink-UL arbiter in front of the core's single-beat peripheral port: it round-robins A-channel requests from two requesters into one registered A output, widens source by one bit to tag the requester, and routes D-channel responses back by that bit. Per-requester in-flight counters cap outstanding transactions and flag unexpected responses. It sits between the requester queues and the TL monitor/slave port.

## Interface
- MAX_INFLIGHT, 2, max outstanding A beats per requester (1..7); counter width 3 bits.
- clock  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- r0_a_valid / r1_a_valid  in  1  requester A valid
- r0_a_ready / r1_a_ready  out  1  requester A ready
- r0_a_bits / r1_a_bits  in  59  {opcode[2:0], param[2:0], size[1:0], source[0], address[13:0], mask[3:0], data[31:0]}
- a_valid  out  1  arbitrated A valid (registered)
- a_ready  in  1  downstream A ready
- a_bits  out  60  same fields, source widened to [1:0] = {requester index, requester source}
- d_valid  in  1  downstream D valid
- d_ready  out  1  downstream D ready
- d_bits  in  43  {opcode[2:0], param[1:0], size[1:0], source[1:0], denied, data[31:0], corrupt}
- r0_d_valid / r1_d_valid  out  1  routed D valid
- r0_d_ready / r1_d_ready  in  1  requester D ready
- r_d_bits  out  42  d_bits with source[1] stripped, shared by both requesters
- err_unexpected_d  out  1  sticky: D beat arrived for a requester with zero in-flight

## Operation
- Output stage: one register (a_valid, a_bits). load = !a_valid || a_ready. On load, takes the granted request or clears a_valid if none.
- Eligibility: rN eligible when rN_a_valid && cnt_N < MAX_INFLIGHT.
- Arbitration: round-robin pointer ptr (1 bit) names the preferred requester; if preferred eligible it wins, else the other if eligible. On a grant with load, ptr <= ~grantee. No grant -> ptr unchanged.
- rN_a_ready = load && grant==N (combinational from valid/counter/ptr/a_ready; no ready->valid loop on requesters).
- a_bits on load: requester fields with source = {N, rN source}.
- Counters cnt_N: +1 when rN_a_valid && rN_a_ready; -1 when d_valid && d_ready && d_bits.source[1]==N && cnt_N!=0. Both same cycle -> unchanged.
- D routing (combinational): rN_d_valid = d_valid && source[1]==N; d_ready = r{source[1]}_d_ready; r_d_bits passes all fields, source[0] only.
- D beat accepted for port N with cnt_N==0: counter stays 0, err_unexpected_d set; cleared only by reset.
- All D responses single-beat; every D handshake retires one transaction.

## Timing
- Reset (async assert, sync release): a_valid=0, a_bits=0, ptr=0, cnt_0=cnt_1=0, err_unexpected_d=0. Reset mid-transaction drops the held beat and all counts.
- A latency: requester handshake in cycle t -> a_valid in t+1. Full throughput: back-to-back one beat/cycle while a_ready=1.
- Backpressure: a_ready=0 with a_valid=1 holds a_bits stable; both rN_a_ready=0.
- D path: zero-cycle, no registers.
- Counter at MAX_INFLIGHT and a D retirement for same port in cycle t: still ineligible in t (uses registered count); eligible t+1.

## Test plan
- Reset: drive reset_n=0 mid-traffic -> all outputs/counters 0 immediately, ptr=0 after release.
- Both requesters continuously valid, a_ready=1, d returns immediately -> grants alternate r0,r1,r0,r1; a_bits.source[1] toggles each cycle.
- r0 only, MAX_INFLIGHT=2, no D -> two beats accepted, r0_a_ready=0 thereafter; one D with source=2'b00 -> third beat accepted next cycle.
- a_ready=0 for 5 cycles with a_valid=1 -> a_bits unchanged, no requester ready; release -> beat drains, next grant loads same cycle.
- D beat source=2'b11 while r1_d_ready=0 -> r1_d_valid=1, d_ready=0; r1_d_ready=1 -> cnt_1 decrements, r_d_bits source=1.
- D beat source=2'b00 with cnt_0=0 -> err_unexpected_d=1 next cycle and stays, cnt_0 remains 0.

Source files
------------

// File: rtl/tl_ul_a_arbiter.sv
// Two-to-one TileLink-UL A-channel round-robin arbiter with a registered A output,
// per-requester in-flight limiting and zero-latency D-channel return routing.
module tl_ul_a_arbiter #(
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        r0_a_valid,
  output logic        r0_a_ready,
  input  logic [58:0] r0_a_bits,
  input  logic        r1_a_valid,
  output logic        r1_a_ready,
  input  logic [58:0] r1_a_bits,
  output logic        a_valid,
  input  logic        a_ready,
  output logic [59:0] a_bits,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [42:0] d_bits,
  output logic        r0_d_valid,
  input  logic        r0_d_ready,
  output logic        r1_d_valid,
  input  logic        r1_d_ready,
  output logic [41:0] r_d_bits,
  output logic        err_unexpected_d
);

  localparam logic [2:0] MaxCnt = 3'(MAX_INFLIGHT);

  logic        a_valid_q, a_valid_d;
  logic [59:0] a_bits_q, a_bits_d;
  logic        ptr_q, ptr_d;
  logic [2:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        err_q, err_d;

  logic        elig0, elig1, load, gnt_valid, gnt_idx;
  logic [58:0] gnt_bits;
  logic        d_sel, d_fire, inc0, inc1, dec0, dec1;

  // Eligibility uses the registered count, so a same-cycle retirement frees a slot next cycle.
  assign elig0     = r0_a_valid && (cnt0_q < MaxCnt);
  assign elig1     = r1_a_valid && (cnt1_q < MaxCnt);
  assign load      = !a_valid_q || a_ready;
  assign gnt_valid = elig0 || elig1;
  assign gnt_idx   = ptr_q ? elig1 : !elig0;
  assign gnt_bits  = gnt_idx ? r1_a_bits : r0_a_bits;

  assign r0_a_ready = load && gnt_valid && !gnt_idx;
  assign r1_a_ready = load && gnt_valid && gnt_idx;

  always_comb begin
    a_valid_d = a_valid_q;
    a_bits_d  = a_bits_q;
    ptr_d     = ptr_q;
    if (load) begin
      a_valid_d = gnt_valid;
      if (gnt_valid) begin
        // Requester index becomes the new source MSB.
        a_bits_d = {gnt_bits[58:51], gnt_idx, gnt_bits[50:0]};
        ptr_d    = !gnt_idx;
      end
    end
  end

  assign d_sel      = d_bits[35];
  assign r0_d_valid = d_valid && !d_sel;
  assign r1_d_valid = d_valid && d_sel;
  assign d_ready    = d_sel ? r1_d_ready : r0_d_ready;
  assign r_d_bits   = {d_bits[42:36], d_bits[34:0]};
  assign d_fire     = d_valid && d_ready;

  assign inc0 = r0_a_valid && r0_a_ready;
  assign inc1 = r1_a_valid && r1_a_ready;
  assign dec0 = d_fire && !d_sel && (cnt0_q != 3'd0);
  assign dec1 = d_fire && d_sel && (cnt1_q != 3'd0);

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (inc0 && !dec0) begin
      cnt0_d = cnt0_q + 3'd1;
    end else if (dec0 && !inc0) begin
      cnt0_d = cnt0_q - 3'd1;
    end
    if (inc1 && !dec1) begin
      cnt1_d = cnt1_q + 3'd1;
    end else if (dec1 && !inc1) begin
      cnt1_d = cnt1_q - 3'd1;
    end
    err_d = err_q || (d_fire && (d_sel ? (cnt1_q == 3'd0) : (cnt0_q == 3'd0)));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q <= 1'b0;
      a_bits_q  <= '0;
      ptr_q     <= 1'b0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_bits_q  <= a_bits_d;
      ptr_q     <= ptr_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
      err_q     <= err_d;
    end
  end

  assign a_valid          = a_valid_q;
  assign a_bits           = a_bits_q;
  assign err_unexpected_d = err_q;

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Directed bench for tl_ul_a_arbiter: expected A beats go into a scoreboard queue when a
// grant is predicted and are popped when the registered output handshakes.
module tb_tl_ul_a_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        r0_a_valid, r0_a_ready, r1_a_valid, r1_a_ready;
  logic [58:0] r0_a_bits, r1_a_bits;
  logic        a_valid, a_ready;
  logic [59:0] a_bits;
  logic        d_valid, d_ready;
  logic [42:0] d_bits;
  logic        r0_d_valid, r0_d_ready, r1_d_valid, r1_d_ready;
  logic [41:0] r_d_bits;
  logic        err_unexpected_d;

  int          total = 0;
  int          bad = 0;
  logic [59:0] exp_q[$];
  logic [59:0] r0_exp, r1_exp;
  logic        fire;
  logic [1:0]  src;

  always #5 clock = ~clock;

  tl_ul_a_arbiter #(.MAX_INFLIGHT(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .r0_a_valid(r0_a_valid), .r0_a_ready(r0_a_ready), .r0_a_bits(r0_a_bits),
    .r1_a_valid(r1_a_valid), .r1_a_ready(r1_a_ready), .r1_a_bits(r1_a_bits),
    .a_valid(a_valid), .a_ready(a_ready), .a_bits(a_bits),
    .d_valid(d_valid), .d_ready(d_ready), .d_bits(d_bits),
    .r0_d_valid(r0_d_valid), .r0_d_ready(r0_d_ready),
    .r1_d_valid(r1_d_valid), .r1_d_ready(r1_d_ready),
    .r_d_bits(r_d_bits), .err_unexpected_d(err_unexpected_d)
  );

  function automatic logic [58:0] req(input logic [2:0] op, input logic s,
                                      input logic [13:0] addr, input logic [31:0] data);
    return {op, 3'b000, 2'b10, s, addr, 4'hf, data};
  endfunction

  function automatic logic [59:0] fwd(input logic [2:0] op, input logic idx, input logic s,
                                      input logic [13:0] addr, input logic [31:0] data);
    return {op, 3'b000, 2'b10, idx, s, addr, 4'hf, data};
  endfunction

  function automatic logic [42:0] dbits(input logic [2:0] op, input logic [1:0] prm,
                                        input logic [1:0] s, input logic den,
                                        input logic [31:0] data, input logic cor);
    return {op, prm, 2'b10, s, den, data, cor};
  endfunction

  function automatic logic [41:0] rdbits(input logic [2:0] op, input logic [1:0] prm,
                                         input logic s, input logic den,
                                         input logic [31:0] data, input logic cor);
    return {op, prm, 2'b10, s, den, data, cor};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic set_r0(input logic [2:0] op, input logic s, input logic [13:0] addr,
                        input logic [31:0] data);
    r0_a_bits = req(op, s, addr, data);
    r0_exp    = fwd(op, 1'b0, s, addr, data);
  endtask

  task automatic set_r1(input logic [2:0] op, input logic s, input logic [13:0] addr,
                        input logic [31:0] data);
    r1_a_bits = req(op, s, addr, data);
    r1_exp    = fwd(op, 1'b1, s, addr, data);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard side: every output handshake must match the oldest predicted beat.
  always @(negedge clock) begin
    if (reset_n && a_valid && a_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL a_beat_extra: got %0h want no beat", a_bits);
      end else begin
        chk("a_beat", 64'(a_bits), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    r0_a_valid = 1'b0; r1_a_valid = 1'b0; r0_a_bits = '0; r1_a_bits = '0;
    a_ready = 1'b0; d_valid = 1'b0; d_bits = '0; r0_d_ready = 1'b0; r1_d_ready = 1'b0;
    r0_exp = '0; r1_exp = '0;
    @(negedge clock);
    chk("rst_a_valid", 64'(a_valid), 64'd0);
    chk("rst_a_bits", 64'(a_bits), 64'd0);
    chk("rst_err", 64'(err_unexpected_d), 64'd0);
    next_cycle();
    reset_n = 1'b1;

    // Both requesters busy, D returned as soon as each beat leaves: strict alternation.
    set_r0(3'd4, 1'b0, 14'h0100, 32'ha0a0_0001);
    set_r1(3'd0, 1'b1, 14'h0200, 32'hb1b1_0002);
    r0_a_valid = 1'b1; r1_a_valid = 1'b1; a_ready = 1'b1;
    r0_d_ready = 1'b1; r1_d_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (k == 8) begin
        r0_a_valid = 1'b0; r1_a_valid = 1'b0;
      end
      @(negedge clock);
      if (k < 8) begin
        chk("alt_r0_ready", 64'(r0_a_ready), 64'(k % 2 == 0));
        chk("alt_r1_ready", 64'(r1_a_ready), 64'(k % 2 == 1));
        if (k % 2 == 0) exp_q.push_back(r0_exp);
        else exp_q.push_back(r1_exp);
      end
      fire = a_valid && a_ready;
      src  = a_bits[51:50];
      next_cycle();
      d_valid = fire;
      d_bits  = dbits(3'd1, 2'b00, src, 1'b0, 32'h0, 1'b0);
    end
    d_valid = 1'b0;
    chk("alt_drained", 64'(exp_q.size()), 64'd0);

    // r0 alone hits the in-flight cap; a retirement frees it only the following cycle.
    set_r0(3'd1, 1'b1, 14'h0333, 32'hc3c3_0003);
    r0_a_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk("sat_r0_ready", 64'(r0_a_ready), 64'(k < 2));
      if (k < 2) exp_q.push_back(r0_exp);
      next_cycle();
    end
    d_valid = 1'b1;
    d_bits  = dbits(3'd1, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    @(negedge clock);
    chk("sat_same_cycle", 64'(r0_a_ready), 64'd0);
    chk("sat_r0_d_valid", 64'(r0_d_valid), 64'd1);
    chk("sat_d_ready", 64'(d_ready), 64'd1);
    next_cycle();
    d_valid = 1'b0;
    @(negedge clock);
    chk("sat_freed", 64'(r0_a_ready), 64'd1);
    exp_q.push_back(r0_exp);
    next_cycle();
    @(negedge clock);
    chk("sat_again", 64'(r0_a_ready), 64'd0);
    next_cycle();
    r0_a_valid = 1'b0;
    d_valid = 1'b1;
    repeat (2) next_cycle();
    d_valid = 1'b0;

    // Backpressure: held beat stays put and nobody is granted until a_ready returns.
    set_r0(3'd0, 1'b0, 14'h0444, 32'hd4d4_0004);
    set_r1(3'd4, 1'b0, 14'h0555, 32'he5e5_0005);
    a_ready = 1'b0; r0_a_valid = 1'b1; r1_a_valid = 1'b1;
    @(negedge clock);
    chk("bp_first_r1", 64'(r1_a_ready), 64'd1);
    chk("bp_first_r0", 64'(r0_a_ready), 64'd0);
    exp_q.push_back(r1_exp);
    next_cycle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("bp_valid", 64'(a_valid), 64'd1);
      chk("bp_bits", 64'(a_bits), 64'(r1_exp));
      chk("bp_no_ready", 64'({r0_a_ready, r1_a_ready}), 64'd0);
      next_cycle();
    end
    a_ready = 1'b1;
    @(negedge clock);
    chk("bp_release_r0", 64'(r0_a_ready), 64'd1);
    chk("bp_release_r1", 64'(r1_a_ready), 64'd0);
    exp_q.push_back(r0_exp);
    next_cycle();
    r0_a_valid = 1'b0; r1_a_valid = 1'b0;
    next_cycle();

    // D routing with requester backpressure; retirement frees one r1 slot.
    d_valid = 1'b1;
    d_bits  = dbits(3'd2, 2'b01, 2'b11, 1'b1, 32'hdead_beef, 1'b1);
    r1_d_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("d_r1_valid", 64'(r1_d_valid), 64'd1);
      chk("d_r0_valid", 64'(r0_d_valid), 64'd0);
      chk("d_ready_held", 64'(d_ready), 64'd0);
      chk("d_bits", 64'(r_d_bits), 64'(rdbits(3'd2, 2'b01, 1'b1, 1'b1, 32'hdead_beef, 1'b1)));
      next_cycle();
    end
    r1_d_ready = 1'b1;
    @(negedge clock);
    chk("d_ready_go", 64'(d_ready), 64'd1);
    next_cycle();
    d_valid = 1'b0;
    set_r1(3'd1, 1'b1, 14'h0666, 32'hf6f6_0006);
    r1_a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("d_r1_slots", 64'(r1_a_ready), 64'(k < 2));
      if (k < 2) exp_q.push_back(r1_exp);
      next_cycle();
    end
    r1_a_valid = 1'b0;
    d_valid = 1'b1;
    d_bits  = dbits(3'd1, 2'b00, 2'b11, 1'b0, 32'h0, 1'b0);
    repeat (2) next_cycle();
    d_bits  = dbits(3'd1, 2'b00, 2'b00, 1'b0, 32'h0, 1'b0);
    next_cycle();
    d_valid = 1'b0;
    @(negedge clock);
    chk("no_err_yet", 64'(err_unexpected_d), 64'd0);
    next_cycle();

    // Unexpected D for r0: sticky error, count stays at zero (two full slots afterwards).
    d_valid = 1'b1;
    @(negedge clock);
    chk("err_before", 64'(err_unexpected_d), 64'd0);
    next_cycle();
    d_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("err_sticky", 64'(err_unexpected_d), 64'd1);
      next_cycle();
    end
    set_r0(3'd4, 1'b1, 14'h0777, 32'h0707_0007);
    r0_a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("err_r0_slots", 64'(r0_a_ready), 64'(k < 2));
      if (k < 2) exp_q.push_back(r0_exp);
      next_cycle();
    end
    r0_a_valid = 1'b0;

    // Reset with a beat held and ptr pointing at r1, r0 at its cap.
    d_valid = 1'b1;
    next_cycle();
    d_valid = 1'b0;
    set_r0(3'd0, 1'b0, 14'h0888, 32'h0808_0008);
    set_r1(3'd0, 1'b0, 14'h0999, 32'h0909_0009);
    a_ready = 1'b0; r0_a_valid = 1'b1;
    @(negedge clock);
    chk("pre_rst_grant", 64'(r0_a_ready), 64'd1);
    exp_q.push_back(r0_exp);
    next_cycle();
    r1_a_valid = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_a_valid", 64'(a_valid), 64'd0);
    chk("mid_rst_a_bits", 64'(a_bits), 64'd0);
    chk("mid_rst_err", 64'(err_unexpected_d), 64'd0);
    exp_q.delete();
    next_cycle();
    reset_n = 1'b1;
    a_ready = 1'b1;
    @(negedge clock);
    chk("post_rst_r0", 64'(r0_a_ready), 64'd1);
    chk("post_rst_r1", 64'(r1_a_ready), 64'd0);
    exp_q.push_back(r0_exp);
    next_cycle();
    @(negedge clock);
    chk("post_rst_next_r1", 64'(r1_a_ready), 64'd1);
    exp_q.push_back(r1_exp);
    next_cycle();
    r0_a_valid = 1'b0; r1_a_valid = 1'b0;
    repeat (2) next_cycle();
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
